// File: rtl/axis_pkg.sv
// Shared AXI-Stream types for the 8-bit frame generator, packet FIFO and sink.
// The frame-forwarding state enum is used only when AXIS_PKT_FIFO_STORE_FWD_EN is defined.
package axis_pkg;

   localparam int unsigned AXIS_DATA_W = 8;

   typedef struct packed {
      logic                   tlast;
      logic [AXIS_DATA_W-1:0] tdata;
   } axis_beat_t;

   typedef enum logic {
      FWD_NORMAL,
      FWD_OVERSIZE
   } fwd_state_e;

endpackage

// File: rtl/axis_fifo_ram.sv
// Beat storage for axis_pkt_fifo: DEPTH x {tlast, tdata}.
// Synchronous write, asynchronous read, no reset on the array.
module axis_fifo_ram
   import axis_pkg::*;
#(
   parameter int unsigned DATA_W = AXIS_DATA_W,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W:0]   i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W:0]   o_rdata
);

   logic [DATA_W:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO between frame generator and throttling sink.
// Define AXIS_PKT_FIFO_STORE_FWD_EN for store-and-forward; default build is cut-through.
module axis_pkt_fifo
   import axis_pkg::*;
#(
   parameter int unsigned DATA_W = AXIS_DATA_W,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              s_tvalid,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tlast,
   output logic              s_tready,
   output logic              m_tvalid,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tlast,
   input  logic              m_tready,
   output logic [AW:0]       level,
   output logic [AW:0]       pkt_count,
   output logic              overflow
);

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [AW:0]     r_wr_ptr;
   logic [AW:0]     r_rd_ptr;
   logic [AW:0]     r_pkt_cnt;
   logic [AW:0]     w_level;
   logic [AW:0]     w_pkt_nxt;
   logic            w_full;
   logic            w_empty;
   logic            w_wr_fire;
   logic            w_rd_fire;
   logic            w_pkt_inc;
   logic            w_pkt_dec;
   logic            w_m_tvalid;
   logic [DATA_W:0] w_rd_entry;

   axis_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr_fire),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata ({s_tlast, s_tdata}),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (w_rd_entry)
   );

   assign w_level   = r_wr_ptr - r_rd_ptr;
   assign w_full    = (w_level == LVL_FULL);
   assign w_empty   = (w_level == '0);
   assign s_tready  = !w_full;
   assign w_wr_fire = s_tvalid && !w_full;
   assign w_rd_fire = w_m_tvalid && m_tready;

   // Storage is not reset, so the head entry is masked while empty.
   assign m_tvalid  = w_m_tvalid;
   assign m_tdata   = w_empty ? '0 : w_rd_entry[DATA_W-1:0];
   assign m_tlast   = !w_empty && w_rd_entry[DATA_W];

   assign w_pkt_inc = w_wr_fire && s_tlast;
   assign w_pkt_dec = w_rd_fire && w_rd_entry[DATA_W];

   assign level     = w_level;
   assign pkt_count = r_pkt_cnt;

   always_comb begin
      w_pkt_nxt = r_pkt_cnt;
      if (w_pkt_inc && !w_pkt_dec) begin
         w_pkt_nxt = r_pkt_cnt + 1'b1;
      end else if (w_pkt_dec && !w_pkt_inc) begin
         w_pkt_nxt = r_pkt_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_pkt_cnt <= '0;
      end else begin
         if (w_wr_fire) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_fire) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_pkt_cnt <= w_pkt_nxt;
      end
   end

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN

   fwd_state_e  r_fwd_state;
   logic        r_overflow;
   logic [AW:0] w_lvl_nxt;

   always_comb begin
      w_lvl_nxt = w_level;
      if (w_wr_fire && !w_rd_fire) begin
         w_lvl_nxt = w_level + 1'b1;
      end else if (w_rd_fire && !w_wr_fire) begin
         w_lvl_nxt = w_level - 1'b1;
      end
   end

   // A full FIFO with no complete frame can only hold part of an oversize
   // frame; release it cut-through until its tlast beat leaves.
   assign w_m_tvalid = !w_empty &&
                       ((r_pkt_cnt != '0) || w_full || (r_fwd_state == FWD_OVERSIZE));
   assign overflow   = r_overflow;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fwd_state <= FWD_NORMAL;
         r_overflow  <= 1'b0;
      end else begin
         case (r_fwd_state)
            FWD_NORMAL: begin
               if ((w_lvl_nxt == LVL_FULL) && (w_pkt_nxt == '0)) begin
                  r_fwd_state <= FWD_OVERSIZE;
                  r_overflow  <= 1'b1;
               end
            end
            FWD_OVERSIZE: begin
               if (w_pkt_dec) begin
                  r_fwd_state <= FWD_NORMAL;
               end
            end
            default: r_fwd_state <= FWD_NORMAL;
         endcase
      end
   end

`else

   assign w_m_tvalid = !w_empty;
   assign overflow   = 1'b0;

`endif

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench for axis_pkt_fifo; honours AXIS_PKT_FIFO_STORE_FWD_EN when defined.
// The reference model is a queue of beats; level, pkt_count and m_tvalid are derived from it.
module tb_axis_pkt_fifo;
   import axis_pkg::*;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic          clk      = 1'b0;
   logic          resetn   = 1'b0;
   logic          s_tvalid = 1'b0;
   logic [DW-1:0] s_tdata  = '0;
   logic          s_tlast  = 1'b0;
   logic          s_tready;
   logic          m_tvalid;
   logic [DW-1:0] m_tdata;
   logic          m_tlast;
   logic          m_tready = 1'b0;
   logic [AW:0]   level;
   logic [AW:0]   pkt_count;
   logic          overflow;

   always #5 clk = ~clk;

   axis_pkt_fifo #(
      .DATA_W (DW),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .s_tvalid  (s_tvalid),
      .s_tdata   (s_tdata),
      .s_tlast   (s_tlast),
      .s_tready  (s_tready),
      .m_tvalid  (m_tvalid),
      .m_tdata   (m_tdata),
      .m_tlast   (m_tlast),
      .m_tready  (m_tready),
      .level     (level),
      .pkt_count (pkt_count),
      .overflow  (overflow)
   );

   int         checks   = 0;
   int         errors   = 0;
   axis_beat_t exp_q[$];
   int         sent     = 0;
   int         rcvd     = 0;
   int         dropped  = 0;
   bit         ov_mode  = 1'b0;
   bit         ovf_exp  = 1'b0;
   int         max_pkt  = 0;
   bit         saw_full = 1'b0;
   int         rdy_mode = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int tl_count();
      int n = 0;
      foreach (exp_q[i]) if (exp_q[i].tlast) n++;
      return n;
   endfunction

   // Model and monitor: outputs compared at negedge, model then advanced as the next edge will.
   always @(negedge clk) begin
      int         sz;
      int         ntl;
      bit         mv;
      axis_beat_t b;
      if (!resetn) begin
         chk("rst_level", level, 0);
         chk("rst_pkt_count", pkt_count, 0);
         chk("rst_m_tvalid", m_tvalid, 0);
         chk("rst_m_tdata", m_tdata, 0);
         chk("rst_m_tlast", m_tlast, 0);
         chk("rst_s_tready", s_tready, 1);
         chk("rst_overflow", overflow, 0);
         dropped += exp_q.size();
         exp_q.delete();
         ov_mode = 1'b0;
         ovf_exp = 1'b0;
      end else begin
         sz  = exp_q.size();
         ntl = tl_count();
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
         mv = (sz != 0) && (ntl != 0 || sz == DEPTH || ov_mode);
`else
         mv = (sz != 0);
`endif
         chk("level", level, sz);
         chk("s_tready", s_tready, (sz != DEPTH));
         chk("m_tvalid", m_tvalid, mv);
         chk("pkt_count", pkt_count, ntl);
         chk("overflow", overflow, ovf_exp);
         if (m_tvalid) begin
            if (sz == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data %0h with empty scoreboard at %0t", m_tdata, $time);
            end else begin
               chk("m_tdata", m_tdata, exp_q[0].tdata);
               chk("m_tlast", m_tlast, exp_q[0].tlast);
               if (m_tready) begin
                  b = exp_q.pop_front();
                  rcvd++;
                  if (ov_mode && b.tlast) ov_mode = 1'b0;
               end
            end
         end
         if (s_tvalid && sz != DEPTH) begin
            b.tlast = s_tlast;
            b.tdata = s_tdata;
            exp_q.push_back(b);
            sent++;
         end
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
         if (!ov_mode && exp_q.size() == DEPTH && tl_count() == 0) begin
            ov_mode = 1'b1;
            ovf_exp = 1'b1;
         end
`endif
         if (level == (AW+1)'(DEPTH)) saw_full = 1'b1;
         if (int'(pkt_count) > max_pkt) max_pkt = int'(pkt_count);
      end
   end

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1)      m_tready = !m_tready;
      else if (rdy_mode == 2) m_tready = 1'($urandom_range(0, 1));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic l);
      bit acc = 1'b0;
      int n   = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      while (!acc) begin
         @(negedge clk);
         acc = s_tready;
         @(posedge clk);
         #1;
         n++;
         if (!acc && n > 300) begin
            chk("send_timeout_ready", s_tready, 1);
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      s_tvalid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic drain();
      int n = 0;
      s_tvalid = 1'b0;
      rdy_mode = 0;
      m_tready = 1'b1;
      while (level != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain_level", level, 0);
   endtask

   task automatic pulse_reset();
      s_tvalid = 1'b0;
      tick();
      resetn = 1'b0;
      #2;
      chk("async_rst_level", level, 0);
      chk("async_rst_m_tvalid", m_tvalid, 0);
      tick();
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;

      // Single 8-beat frame, sink always ready.
      m_tready = 1'b1;
      for (int i = 0; i < 8; i++) send(8'(i), (i == 7));
      idle(1);
      drain();

      // Back-to-back frames against a sink ready every other cycle.
      pulse_reset();
      saw_full = 1'b0;
      max_pkt  = 0;
      rdy_mode = 1;
      for (int f = 0; f < 10; f++)
         for (int i = 0; i < 8; i++) send(8'(i), (i == 7));
      chk("toggle_saw_full", saw_full, 1);
      chk("toggle_pkt_max_le2", (max_pkt <= 2), 1);
      drain();

      // Fill with sink stalled, then stream while draining across the wrap.
      rdy_mode = 0;
      m_tready = 1'b0;
      for (int i = 0; i < 16; i++) send(8'(8'h40 + i), (i % 4 == 3));
      chk("fill_s_tready", s_tready, 0);
      chk("fill_level", level, DEPTH);
      m_tready = 1'b1;
      for (int i = 0; i < 10; i++) send(8'(8'h80 + i), (i % 5 == 4));
      drain();

      // Simultaneous tlast write and tlast read with one frame stored.
      m_tready = 1'b0;
      send(8'hA5, 1'b1);
      m_tready = 1'b1;
      send(8'h5A, 1'b1);
      chk("simul_level", level, 1);
      chk("simul_pkt_count", pkt_count, 1);
      drain();

      // 20-beat frame, longer than the FIFO.
      m_tready = 1'b0;
      for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
      chk("oversize_m_tvalid", m_tvalid, 1);
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
      chk("oversize_overflow", overflow, 1);
`else
      chk("oversize_overflow", overflow, 0);
`endif
      m_tready = 1'b1;
      for (int i = 16; i < 20; i++) send(8'(i), (i == 19));
      drain();

      // Reset in the middle of a partly stored frame.
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) send(8'(8'hC0 + i), 1'b0);
      s_tvalid = 1'b0;
      chk("midframe_level", level, 5);
      pulse_reset();
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) send(8'(8'hD0 + i), (i == 3));
      drain();

      // Random traffic with random back-pressure.
      rdy_mode = 2;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         send(8'($urandom), ($urandom_range(0, 5) == 0));
      end
      send(8'hFF, 1'b1);
      drain();
      idle(2);

      chk("scoreboard_empty", exp_q.size(), 0);
      chk("beats_conserved", rcvd + dropped, sent);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
